// File: rtl/rename_register_file_pkg.sv
// Shared constants for the rename register file and its read ports.
package rename_register_file_pkg;

    localparam int ROB_WIDTH      = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int XLEN           = 32;
    localparam int REG_COUNT      = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rename_read_port.sv
// One source-operand lookup: resolves a register to a ready value or a pending ROB tag.
module rename_read_port
    import rename_register_file_pkg::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  logic [REG_ADDR_WIDTH-1:0] idx_i,
    input  logic                      busy_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    input  logic [XLEN-1:0]           reg_value_i,
    input  logic                      commit_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] commit_dest_i,
    input  logic [XLEN-1:0]           commit_value_i,
    input  logic [TAG_WIDTH-1:0]      commit_rob_id_i,
    input  logic                      rob_ready_i,
    input  logic [XLEN-1:0]           rob_value_i,
    output logic                      ready_o,
    output logic [XLEN-1:0]           value_o,
    output logic [TAG_WIDTH-1:0]      dep_o,
    output logic [TAG_WIDTH-1:0]      rob_dep_o
);

    logic commit_bypass;

    assign commit_bypass = commit_valid_i && (commit_dest_i == idx_i) && (commit_rob_id_i == tag_i);

    // The ROB is always asked about the current rename tag, even when it is not needed.
    assign rob_dep_o = tag_i;

    // Priority mux: x0, architectural value, same-cycle commit, ROB-held value, else wait on tag.
    always_comb begin
        ready_o = 1'b0;
        value_o = '0;
        dep_o   = tag_i;
        if (idx_i == ZERO_REG) begin
            ready_o = 1'b1;
            dep_o   = '0;
        end else if (!busy_i) begin
            ready_o = 1'b1;
            value_o = reg_value_i;
            dep_o   = '0;
        end else if (commit_bypass) begin
            ready_o = 1'b1;
            value_o = commit_value_i;
        end else if (rob_ready_i) begin
            ready_o = 1'b1;
            value_o = rob_value_i;
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register busy bit and ROB rename tag.
module rename_register_file
#(
    parameter int ROB_WIDTH = rename_register_file_pkg::ROB_WIDTH,
    parameter int REG_COUNT = rename_register_file_pkg::REG_COUNT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 regUpdateValid,
    input  logic [4:0]           regUpdateDest,
    input  logic [31:0]          regValue,
    input  logic [ROB_WIDTH-1:0] regUpdateRobId,
    input  logic                 renameValid,
    input  logic [4:0]           renameDest,
    input  logic [ROB_WIDTH-1:0] renameRobId,
    input  logic [4:0]           rs1Index,
    output logic                 rs1Ready,
    output logic [31:0]          rs1Value,
    output logic [ROB_WIDTH-1:0] rs1Dep,
    input  logic [4:0]           rs2Index,
    output logic                 rs2Ready,
    output logic [31:0]          rs2Value,
    output logic [ROB_WIDTH-1:0] rs2Dep,
    output logic [ROB_WIDTH-1:0] robRs1Dep,
    input  logic                 robRs1Ready,
    input  logic [31:0]          robRs1Value,
    output logic [ROB_WIDTH-1:0] robRs2Dep,
    input  logic                 robRs2Ready,
    input  logic [31:0]          robRs2Value
);

    import rename_register_file_pkg::*;

    // Flattened views of the per-register state for the read muxes.
    logic [XLEN-1:0]      regs_view [REG_COUNT];
    logic                 busy_view [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_view  [REG_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            localparam logic [REG_ADDR_WIDTH-1:0] MY_IDX = REG_ADDR_WIDTH'(gi);

            logic [XLEN-1:0]      reg_q,  reg_d;
            logic                 busy_q, busy_d;
            logic [ROB_WIDTH-1:0] tag_q,  tag_d;
            logic                 commit_hit;
            logic                 rename_hit;

            // x0 never matches, so it stays at its reset value forever.
            assign commit_hit = regUpdateValid && (regUpdateDest == MY_IDX) && (MY_IDX != ZERO_REG);
            assign rename_hit = renameValid && (renameDest == MY_IDX) && (MY_IDX != ZERO_REG);

            // Next state: commit writes the value; clear beats rename, rename beats retire.
            always_comb begin
                reg_d  = reg_q;
                busy_d = busy_q;
                tag_d  = tag_q;
                if (commit_hit) begin
                    reg_d = regValue;
                end
                if (clear) begin
                    busy_d = 1'b0;
                end else if (rename_hit) begin
                    busy_d = 1'b1;
                    tag_d  = renameRobId;
                end else if (commit_hit && busy_q && (tag_q == regUpdateRobId)) begin
                    busy_d = 1'b0;
                end
            end

            // State register with synchronous reset.
            always_ff @(posedge clockIn) begin
                if (resetIn) begin
                    reg_q  <= '0;
                    busy_q <= 1'b0;
                    tag_q  <= '0;
                end else begin
                    reg_q  <= reg_d;
                    busy_q <= busy_d;
                    tag_q  <= tag_d;
                end
            end

            assign regs_view[gi] = reg_q;
            assign busy_view[gi] = busy_q;
            assign tag_view[gi]  = tag_q;
        end
    endgenerate

    rename_read_port #(.TAG_WIDTH(ROB_WIDTH)) u_rs1 (
        .idx_i           (rs1Index),
        .busy_i          (busy_view[rs1Index]),
        .tag_i           (tag_view[rs1Index]),
        .reg_value_i     (regs_view[rs1Index]),
        .commit_valid_i  (regUpdateValid),
        .commit_dest_i   (regUpdateDest),
        .commit_value_i  (regValue),
        .commit_rob_id_i (regUpdateRobId),
        .rob_ready_i     (robRs1Ready),
        .rob_value_i     (robRs1Value),
        .ready_o         (rs1Ready),
        .value_o         (rs1Value),
        .dep_o           (rs1Dep),
        .rob_dep_o       (robRs1Dep)
    );

    rename_read_port #(.TAG_WIDTH(ROB_WIDTH)) u_rs2 (
        .idx_i           (rs2Index),
        .busy_i          (busy_view[rs2Index]),
        .tag_i           (tag_view[rs2Index]),
        .reg_value_i     (regs_view[rs2Index]),
        .commit_valid_i  (regUpdateValid),
        .commit_dest_i   (regUpdateDest),
        .commit_value_i  (regValue),
        .commit_rob_id_i (regUpdateRobId),
        .rob_ready_i     (robRs2Ready),
        .rob_value_i     (robRs2Value),
        .ready_o         (rs2Ready),
        .value_o         (rs2Value),
        .dep_o           (rs2Dep),
        .rob_dep_o       (robRs2Dep)
    );

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus a random run
// checked against an array-based model of the register/busy/tag state.
module tb_rename_register_file;

    logic        clockIn = 1'b0;
    logic        resetIn, clear;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regValue;
    logic [3:0]  regUpdateRobId;
    logic        renameValid;
    logic [4:0]  renameDest;
    logic [3:0]  renameRobId;
    logic [4:0]  rs1Index, rs2Index;
    logic        rs1Ready, rs2Ready;
    logic [31:0] rs1Value, rs2Value;
    logic [3:0]  rs1Dep, rs2Dep;
    logic [3:0]  robRs1Dep, robRs2Dep;
    logic        robRs1Ready, robRs2Ready;
    logic [31:0] robRs1Value, robRs2Value;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic [3:0]  m_tag  [32];

    always #5 clockIn = ~clockIn;

    rename_register_file dut (
        .clockIn(clockIn), .resetIn(resetIn), .clear(clear),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regValue(regValue), .regUpdateRobId(regUpdateRobId),
        .renameValid(renameValid), .renameDest(renameDest), .renameRobId(renameRobId),
        .rs1Index(rs1Index), .rs1Ready(rs1Ready), .rs1Value(rs1Value), .rs1Dep(rs1Dep),
        .rs2Index(rs2Index), .rs2Ready(rs2Ready), .rs2Value(rs2Value), .rs2Dep(rs2Dep),
        .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
        .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value)
    );

    // Apply the effect of one clock edge to the model using the inputs present at the edge.
    task automatic model_edge();
        bit retire;
        if (resetIn) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
            return;
        end
        retire = 0;
        if (regUpdateValid && regUpdateDest != 0) begin
            m_regs[regUpdateDest] = regValue;
            retire = m_busy[regUpdateDest] && (m_tag[regUpdateDest] == regUpdateRobId);
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            if (retire) m_busy[regUpdateDest] = 0;
            if (renameValid && renameDest != 0) begin
                m_busy[renameDest] = 1;
                m_tag[renameDest]  = renameRobId;
            end
        end
    endtask

    // Expected lookup result for a source register given the current model and inputs.
    function automatic void model_read(input int idx, input bit rob_rdy, input logic [31:0] rob_val,
                                       output bit rdy, output logic [31:0] val,
                                       output logic [3:0] dep, output bit dep_chk);
        rdy = 1; val = 0; dep = 0; dep_chk = 1;
        if (idx == 0) begin
        end else if (!m_busy[idx]) begin
            val = m_regs[idx];
        end else if (regUpdateValid && regUpdateDest == idx && regUpdateRobId == m_tag[idx]) begin
            val = regValue; dep_chk = 0;
        end else if (rob_rdy) begin
            val = rob_val; dep_chk = 0;
        end else begin
            rdy = 0; dep = m_tag[idx];
        end
    endfunction

    task automatic tick();
        @(posedge clockIn);
        model_edge();
        @(negedge clockIn);
    endtask

    task automatic idle();
        resetIn = 0; clear = 0;
        regUpdateValid = 0; regUpdateDest = 0; regValue = 0; regUpdateRobId = 0;
        renameValid = 0; renameDest = 0; renameRobId = 0;
        robRs1Ready = 0; robRs1Value = 0; robRs2Ready = 0; robRs2Value = 0;
    endtask

    task automatic test_reset();
        idle();
        resetIn = 1;
        tick();
        resetIn = 0;
        for (int i = 0; i < 32; i++) begin
            rs1Index = 5'(i); rs2Index = 5'(31 - i);
            #1;
            n_cmp++;
            if (rs1Ready !== 1'b1 || rs1Value !== 32'h0 || rs1Dep !== 4'h0 || robRs1Dep !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_rs1 x%0d got rdy=%b val=%h dep=%h robdep=%h exp 1/0/0/0",
                         i, rs1Ready, rs1Value, rs1Dep, robRs1Dep);
            end
            n_cmp++;
            if (rs2Ready !== 1'b1 || rs2Value !== 32'h0 || rs2Dep !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_rs2 x%0d got rdy=%b val=%h dep=%h exp 1/0/0", 31 - i, rs2Ready, rs2Value, rs2Dep);
            end
            tick();
        end
        renameValid = 1; renameDest = 0; renameRobId = 3;
        tick();
        idle();
        rs1Index = 0;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'h0 || rs1Dep !== 4'h0) begin
            n_fail++;
            $display("FAIL rename_x0 got rdy=%b val=%h dep=%h exp 1/0/0", rs1Ready, rs1Value, rs1Dep);
        end
        $display("test_reset done");
    endtask

    task automatic test_rename_dep();
        idle();
        renameValid = 1; renameDest = 5; renameRobId = 2;
        rs1Index = 5;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'h0) begin
            n_fail++;
            $display("FAIL same_cycle_rename got rdy=%b val=%h exp 1/0", rs1Ready, rs1Value);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b0 || rs1Dep !== 4'd2 || robRs1Dep !== 4'd2 || rs1Value !== 32'h0) begin
            n_fail++;
            $display("FAIL rename_pending got rdy=%b dep=%h robdep=%h val=%h exp 0/2/2/0",
                     rs1Ready, rs1Dep, robRs1Dep, rs1Value);
        end
        robRs1Ready = 1; robRs1Value = 32'h55;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'h55) begin
            n_fail++;
            $display("FAIL rob_forward got rdy=%b val=%h exp 1/00000055", rs1Ready, rs1Value);
        end
        $display("test_rename_dep done");
    endtask

    task automatic test_commit_bypass();
        idle();
        regUpdateValid = 1; regUpdateDest = 5; regValue = 32'hABCD; regUpdateRobId = 2;
        rs1Index = 5; rs2Index = 5;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'hABCD) begin
            n_fail++;
            $display("FAIL commit_bypass got rdy=%b val=%h exp 1/0000abcd", rs1Ready, rs1Value);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs2Ready !== 1'b1 || rs2Value !== 32'hABCD || rs2Dep !== 4'h0) begin
            n_fail++;
            $display("FAIL commit_retired got rdy=%b val=%h dep=%h exp 1/0000abcd/0", rs2Ready, rs2Value, rs2Dep);
        end
        $display("test_commit_bypass done");
    endtask

    task automatic test_stale_commit();
        idle();
        renameValid = 1; renameDest = 7; renameRobId = 1;
        tick();
        renameRobId = 4;
        tick();
        idle();
        regUpdateValid = 1; regUpdateDest = 7; regValue = 32'h11; regUpdateRobId = 1;
        rs1Index = 7;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b0 || rs1Dep !== 4'd4) begin
            n_fail++;
            $display("FAIL stale_no_bypass got rdy=%b dep=%h exp 0/4", rs1Ready, rs1Dep);
        end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b0 || rs1Dep !== 4'd4) begin
            n_fail++;
            $display("FAIL stale_still_busy got rdy=%b dep=%h exp 0/4", rs1Ready, rs1Dep);
        end
        clear = 1;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'h11) begin
            n_fail++;
            $display("FAIL stale_value_written got rdy=%b val=%h exp 1/00000011", rs1Ready, rs1Value);
        end
        $display("test_stale_commit done");
    endtask

    task automatic test_commit_rename_same();
        idle();
        renameValid = 1; renameDest = 9; renameRobId = 6;
        tick();
        regUpdateValid = 1; regUpdateDest = 9; regValue = 32'h22; regUpdateRobId = 6;
        renameRobId = 8;
        tick();
        idle();
        rs2Index = 9;
        #1;
        n_cmp++;
        if (rs2Ready !== 1'b0 || rs2Dep !== 4'd8 || robRs2Dep !== 4'd8) begin
            n_fail++;
            $display("FAIL rename_beats_commit got rdy=%b dep=%h robdep=%h exp 0/8/8", rs2Ready, rs2Dep, robRs2Dep);
        end
        clear = 1;
        tick();
        idle();
        #1;
        n_cmp++;
        if (rs2Ready !== 1'b1 || rs2Value !== 32'h22) begin
            n_fail++;
            $display("FAIL commit_value_kept got rdy=%b val=%h exp 1/00000022", rs2Ready, rs2Value);
        end
        $display("test_commit_rename_same done");
    endtask

    task automatic test_clear_and_reset();
        int regs_list [4] = '{3, 4, 6, 10};
        logic [31:0] exp_vals [4] = '{32'h333, 32'h0, 32'h0, 32'h0};
        idle();
        regUpdateValid = 1; regUpdateDest = 3; regValue = 32'h333; regUpdateRobId = 0;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            renameValid = 1; renameDest = 5'(regs_list[i]); renameRobId = 4'(i + 1);
            tick();
        end
        idle();
        clear = 1; renameValid = 1; renameDest = 10; renameRobId = 5;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            rs1Index = 5'(regs_list[i]);
            #1;
            n_cmp++;
            if (rs1Ready !== 1'b1 || rs1Value !== exp_vals[i]) begin
                n_fail++;
                $display("FAIL clear_x%0d got rdy=%b val=%h exp 1/%h", regs_list[i], rs1Ready, rs1Value, exp_vals[i]);
            end
        end
        renameValid = 1; renameDest = 3; renameRobId = 7;
        tick();
        idle();
        resetIn = 1;
        tick();
        idle();
        rs1Index = 3; rs2Index = 5;
        #1;
        n_cmp++;
        if (rs1Ready !== 1'b1 || rs1Value !== 32'h0 || rs1Dep !== 4'h0 ||
            rs2Ready !== 1'b1 || rs2Value !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op got rs1 %b/%h/%h rs2 %b/%h exp 1/0/0 1/0",
                     rs1Ready, rs1Value, rs1Dep, rs2Ready, rs2Value);
        end
        $display("test_clear_and_reset done");
    endtask

    task automatic test_random();
        bit          e_rdy, dchk;
        logic [31:0] e_val;
        logic [3:0]  e_dep;
        bit          a_rdy;
        logic [31:0] a_val;
        logic [3:0]  a_dep, a_rdep;
        int          idx;
        int          bad = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            resetIn        = ($urandom_range(63) == 0);
            clear          = ($urandom_range(15) == 0);
            regUpdateValid = $urandom_range(1);
            regUpdateDest  = 5'($urandom_range(7));
            regValue       = $urandom;
            regUpdateRobId = $urandom_range(1) ? m_tag[regUpdateDest] : 4'($urandom_range(15));
            renameValid    = $urandom_range(1);
            renameDest     = 5'($urandom_range(7));
            renameRobId    = 4'($urandom_range(15));
            rs1Index       = $urandom_range(2) == 0 ? regUpdateDest : 5'($urandom_range(7));
            rs2Index       = 5'($urandom_range(31));
            robRs1Ready    = ($urandom_range(3) == 0);
            robRs1Value    = $urandom;
            robRs2Ready    = ($urandom_range(3) == 0);
            robRs2Value    = $urandom;
            #1;
            for (int p = 0; p < 2; p++) begin
                idx    = (p == 0) ? rs1Index : rs2Index;
                a_rdy  = (p == 0) ? rs1Ready : rs2Ready;
                a_val  = (p == 0) ? rs1Value : rs2Value;
                a_dep  = (p == 0) ? rs1Dep : rs2Dep;
                a_rdep = (p == 0) ? robRs1Dep : robRs2Dep;
                model_read(idx, (p == 0) ? robRs1Ready : robRs2Ready,
                           (p == 0) ? robRs1Value : robRs2Value, e_rdy, e_val, e_dep, dchk);
                n_cmp++;
                if (a_rdy !== e_rdy || a_val !== e_val || (dchk && a_dep !== e_dep) || a_rdep !== m_tag[idx]) begin
                    n_fail++;
                    bad++;
                    $display("FAIL random_rs%0d cyc=%0d x%0d got rdy=%b val=%h dep=%h robdep=%h exp %b/%h/%h/%h",
                             p + 1, cyc, idx, a_rdy, a_val, a_dep, a_rdep, e_rdy, e_val, e_dep, m_tag[idx]);
                end
            end
            tick();
        end
        $display("test_random done, %0d bad cycles", bad);
    endtask

    initial begin
        rs1Index = 0; rs2Index = 0;
        idle();
        resetIn = 1;
        @(negedge clockIn);
        test_reset();
        test_rename_dep();
        test_commit_bypass();
        test_stale_commit();
        test_commit_rename_same();
        test_clear_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
